// File: rtl/timer_pkg.sv
// Shared opcodes and mode encoding for the multi-channel timer.
package timer_pkg;

  localparam logic [2:0] OPC_SET_INIT    = 3'b000;
  localparam logic [2:0] OPC_SET_PRE     = 3'b001;
  localparam logic [2:0] OPC_DISABLE     = 3'b010;
  localparam logic [2:0] OPC_EN_ONESHOT  = 3'b011;
  localparam logic [2:0] OPC_EN_PERIODIC = 3'b100;
  localparam logic [2:0] OPC_CLEAR       = 3'b101;
  localparam logic [2:0] OPC_SET_MASK    = 3'b110;
  localparam logic [2:0] OPC_RSVD        = 3'b111;

  typedef enum logic [2:0] {
    OP_SET_INIT    = OPC_SET_INIT,
    OP_SET_PRE     = OPC_SET_PRE,
    OP_DISABLE     = OPC_DISABLE,
    OP_EN_ONESHOT  = OPC_EN_ONESHOT,
    OP_EN_PERIODIC = OPC_EN_PERIODIC,
    OP_CLEAR       = OPC_CLEAR,
    OP_SET_MASK    = OPC_SET_MASK,
    OP_RSVD        = OPC_RSVD
  } timer_op_e;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_e;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: 2^P prescaler, one-shot/periodic reload,
// sticky done and missed flags.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 30,
  parameter int PRE_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_en,
  input  timer_op_e        cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             done,
  output logic             missed
);

  localparam int PS_W = (1 << PRE_W) - 1;

  logic [CNT_W-1:0] init_q, init_d, count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d, pact_q, pact_d;
  logic [PS_W-1:0]  presc_q, presc_d, tick_mask;
  timer_mode_e      mode_q, mode_d;
  logic             running_q, running_d, done_q, done_d, missed_q, missed_d;
  logic             tick, expire, is_clear, is_enable;

  always_comb begin
    init_d    = init_q;
    pre_d     = pre_q;
    pact_d    = pact_q;
    count_d   = count_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    running_d = running_q;
    done_d    = done_q;
    missed_d  = missed_q;

    // Terminal prescale value is 2^P-1; for the widest P the shift empties and the mask is all ones.
    tick_mask = ~({PS_W{1'b1}} << pact_q);
    tick      = (presc_q == tick_mask);
    expire    = running_q && tick && (count_q == CNT_W'(1));
    is_clear  = cmd_en && (cmd_op == OP_CLEAR);
    is_enable = cmd_en && ((cmd_op == OP_EN_ONESHOT) || (cmd_op == OP_EN_PERIODIC))
                && (init_q != '0);

    if (running_q) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
      if (tick) count_d = count_q - CNT_W'(1);
    end

    if (cmd_en) begin
      case (cmd_op)
        OP_SET_INIT: init_d = cmd_data;
        OP_SET_PRE:  pre_d = cmd_data[PRE_W-1:0];
        OP_DISABLE:  running_d = 1'b0;
        OP_CLEAR: begin
          done_d   = 1'b0;
          missed_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Expiry overrides a same-cycle CLEAR; a same-cycle DISABLE still leaves running low.
    if (expire) begin
      done_d = 1'b1;
      if (done_q && !is_clear) missed_d = 1'b1;
      if (mode_q == PERIODIC) begin
        count_d = init_q;
        pact_d  = pre_q;
      end else begin
        count_d   = '0;
        running_d = 1'b0;
      end
    end

    if (is_enable) begin
      count_d   = init_q;
      presc_d   = '0;
      pact_d    = pre_q;
      running_d = 1'b1;
      done_d    = 1'b0;
      missed_d  = 1'b0;
      mode_d    = (cmd_op == OP_EN_PERIODIC) ? PERIODIC : ONESHOT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q    <= '0;
      pre_q     <= '0;
      pact_q    <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      mode_q    <= ONESHOT;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      init_q    <= init_d;
      pre_q     <= pre_d;
      pact_q    <= pact_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      running_q <= running_d;
      done_q    <= done_d;
      missed_q  <= missed_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign missed  = missed_q;

endmodule

// File: rtl/timer_multi.sv
// N-channel programmable timer with aggregated registered interrupt.
// Optional TIMER_IRQ_MASK_EN adds a per-channel interrupt mask written by opcode 110.
module timer_multi
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 30,
  parameter int PRE_W = 5,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  timer_op_e        wr_op,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_count,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  done,
  output logic [N_CH-1:0]  missed,
  output logic             irq
);

  logic [CNT_W-1:0] cnt_arr [N_CH];
  logic             irq_q, irq_d;

  // Out-of-range wr_ch matches no instance, so the command is dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd_en  (wr_en && (wr_ch == CH_W'(i))),
      .cmd_op  (wr_op),
      .cmd_data(wr_data),
      .count   (cnt_arr[i]),
      .running (running[i]),
      .done    (done[i]),
      .missed  (missed[i])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_count = cnt_arr[i];
    end
  end

`ifdef TIMER_IRQ_MASK_EN
  logic [N_CH-1:0] irq_mask_q, irq_mask_d;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && (wr_op == OP_SET_MASK)) irq_mask_d = wr_data[N_CH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_mask_q <= '0;
    else          irq_mask_q <= irq_mask_d;
  end

  assign irq_d = |(done & irq_mask_q);
`else
  assign irq_d = |done;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed and randomized bench for timer_multi against a deadline-based reference model.
module tb_timer_multi;
  import timer_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 30;
  localparam int PRE_W = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_ch = '0;
  timer_op_e        wr_op = OP_SET_INIT;
  logic [CNT_W-1:0] wr_data = '0;
  logic [1:0]       rd_ch = '0;
  logic [CNT_W-1:0] rd_count;
  logic [N_CH-1:0]  running, done, missed;
  logic             irq;

  int nvec = 0;
  int nerr = 0;
  longint cyc = 0;

  // Reference model: each running channel has a period start edge and an expiry deadline.
  longint m_init [N_CH], m_p [N_CH], m_ia [N_CH], m_pa [N_CH], m_frz [N_CH], m_ps [N_CH];
  bit     m_per [N_CH], m_run [N_CH], m_done [N_CH], m_miss [N_CH];
  bit [N_CH-1:0] m_mask;
  bit     m_irq;

  timer_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_op(wr_op),
    .wr_data(wr_data), .rd_ch(rd_ch), .rd_count(rd_count), .running(running),
    .done(done), .missed(missed), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_init[c] = 0; m_p[c] = 0; m_ia[c] = 0; m_pa[c] = 0; m_frz[c] = 0; m_ps[c] = 0;
      m_per[c] = 0; m_run[c] = 0; m_done[c] = 0; m_miss[c] = 0;
    end
    m_mask = '0;
    m_irq = 0;
  endtask

  function automatic longint m_count(int c);
    if (m_run[c]) return m_ia[c] - ((cyc - m_ps[c]) >> m_pa[c]);
    return m_frz[c];
  endfunction

  task automatic mdl_edge(bit en, int ch, int op, longint data);
    bit irq_n;
    bit cmd_c, clr, expd, done_old;
    longint li, lp;
    irq_n = 0;
    for (int c = 0; c < N_CH; c++) begin
`ifdef TIMER_IRQ_MASK_EN
      if (m_done[c] && m_mask[c]) irq_n = 1;
`else
      if (m_done[c]) irq_n = 1;
`endif
    end
`ifdef TIMER_IRQ_MASK_EN
    if (en && op == 6) m_mask = data[N_CH-1:0];
`endif
    for (int c = 0; c < N_CH; c++) begin
      cmd_c = en && (ch == c);
      clr = cmd_c && (op == 5);
      expd = m_run[c] && (cyc == m_ps[c] + (m_ia[c] << m_pa[c]));
      done_old = m_done[c];
      li = m_init[c];
      lp = m_p[c];
      if (cmd_c && op == 0) m_init[c] = data & ((longint'(1) << CNT_W) - 1);
      if (cmd_c && op == 1) m_p[c] = data & 31;
      if (clr) begin m_done[c] = 0; m_miss[c] = 0; end
      if (expd) begin
        m_done[c] = 1;
        if (done_old && !clr) m_miss[c] = 1;
        if (m_per[c]) begin m_ps[c] = cyc; m_ia[c] = li; m_pa[c] = lp; end
        else begin m_run[c] = 0; m_frz[c] = 0; end
      end
      if (cmd_c && op == 2 && m_run[c]) begin m_frz[c] = m_count(c); m_run[c] = 0; end
      if (cmd_c && (op == 3 || op == 4) && li != 0) begin
        m_ps[c] = cyc; m_ia[c] = li; m_pa[c] = lp; m_per[c] = (op == 4);
        m_run[c] = 1; m_done[c] = 0; m_miss[c] = 0;
      end
    end
    m_irq = irq_n;
  endtask

  task automatic apply(bit en, int ch, int op, longint data);
    wr_en = en;
    wr_ch = ch[1:0];
    wr_op = timer_op_e'(op[2:0]);
    wr_data = data[CNT_W-1:0];
    @(posedge clk);
    cyc++;
    mdl_edge(en, ch, op, data);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) apply(0, 0, 0, 0);
  endtask

  task automatic cmd(int ch, int op, longint data);
    apply(1, ch, op, data);
  endtask

  task automatic test_reset();
    #3;
    nvec++; if (running !== '0) begin nerr++; $display("FAIL reset_running: got %b want 0000", running); end
    nvec++; if (done !== '0) begin nerr++; $display("FAIL reset_done: got %b want 0000", done); end
    nvec++; if (missed !== '0) begin nerr++; $display("FAIL reset_missed: got %b want 0000", missed); end
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int c = 0; c < N_CH; c++) begin
      rd_ch = c[1:0];
      #1;
      nvec++; if (rd_count !== '0) begin nerr++; $display("FAIL reset_rd_count[%0d]: got %0d want 0", c, rd_count); end
    end
    #4;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mdl_reset();
  endtask

  task automatic test_oneshot();
    rd_ch = 2'd0;
    cmd(0, 0, 250); cmd(0, 1, 2); cmd(0, 3, 0);
    nvec++; if (running[0] !== 1'b1) begin nerr++; $display("FAIL oneshot_running: got %b want 1", running[0]); end
    nvec++; if (rd_count !== 30'd250) begin nerr++; $display("FAIL oneshot_count0: got %0d want 250", rd_count); end
    idle(999);
    nvec++; if (done[0] !== 1'b0) begin nerr++; $display("FAIL oneshot_early: got %b want 0", done[0]); end
    nvec++; if (rd_count !== 30'd1) begin nerr++; $display("FAIL oneshot_count999: got %0d want 1", rd_count); end
    idle(1);
    nvec++; if (done[0] !== 1'b1) begin nerr++; $display("FAIL oneshot_done: got %b want 1", done[0]); end
    nvec++; if (running[0] !== 1'b0) begin nerr++; $display("FAIL oneshot_stop: got %b want 0", running[0]); end
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL oneshot_irq_lag: got %b want 0", irq); end
    idle(1);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    cmd(0, 5, 0);
    nvec++; if (done[0] !== 1'b0) begin nerr++; $display("FAIL oneshot_clear: got %b want 0", done[0]); end
    idle(1);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL oneshot_irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    rd_ch = 2'd1;
    cmd(1, 0, 10); cmd(1, 1, 0); cmd(1, 4, 0);
    idle(9);
    nvec++; if (done[1] !== 1'b0) begin nerr++; $display("FAIL per_early: got %b want 0", done[1]); end
    idle(1);
    nvec++; if (done[1] !== 1'b1) begin nerr++; $display("FAIL per_done10: got %b want 1", done[1]); end
    nvec++; if (running[1] !== 1'b1) begin nerr++; $display("FAIL per_running: got %b want 1", running[1]); end
    nvec++; if (rd_count !== 30'd10) begin nerr++; $display("FAIL per_reload: got %0d want 10", rd_count); end
    idle(4); cmd(1, 5, 0);
    nvec++; if (done[1] !== 1'b0) begin nerr++; $display("FAIL per_clear15: got %b want 0", done[1]); end
    idle(5);
    nvec++; if (done[1] !== 1'b1) begin nerr++; $display("FAIL per_done20: got %b want 1", done[1]); end
    nvec++; if (missed[1] !== 1'b0) begin nerr++; $display("FAIL per_nomiss20: got %b want 0", missed[1]); end
    idle(10);
    nvec++; if (missed[1] !== 1'b1) begin nerr++; $display("FAIL per_missed30: got %b want 1", missed[1]); end
    idle(9); cmd(1, 5, 0);
    nvec++; if (done[1] !== 1'b1) begin nerr++; $display("FAIL per_clr_exp_done: got %b want 1", done[1]); end
    nvec++; if (missed[1] !== 1'b0) begin nerr++; $display("FAIL per_clr_exp_miss: got %b want 0", missed[1]); end
    idle(9); cmd(1, 2, 0);
    nvec++; if (running[1] !== 1'b0) begin nerr++; $display("FAIL per_dis_exp_run: got %b want 0", running[1]); end
    nvec++; if (missed[1] !== 1'b1) begin nerr++; $display("FAIL per_dis_exp_miss: got %b want 1", missed[1]); end
    nvec++; if (rd_count !== 30'd10) begin nerr++; $display("FAIL per_dis_exp_cnt: got %0d want 10", rd_count); end
    cmd(1, 5, 0);
    idle(2);
  endtask

  task automatic test_concurrent();
    rd_ch = 2'd2;
    cmd(2, 0, 500); cmd(2, 1, 4); cmd(3, 0, 100); cmd(3, 1, 1);
    cmd(2, 3, 0); cmd(3, 3, 0);
    idle(199);
    nvec++; if (done[3] !== 1'b0) begin nerr++; $display("FAIL conc_ch3_early: got %b want 0", done[3]); end
    idle(1);
    nvec++; if (done[3:2] !== 2'b10) begin nerr++; $display("FAIL conc_ch3_done: got %b want 10", done[3:2]); end
    nvec++; if (rd_count !== 30'd488) begin nerr++; $display("FAIL conc_ch2_cnt: got %0d want 488", rd_count); end
    idle(7798);
    nvec++; if (done[2] !== 1'b0 || running[2] !== 1'b1) begin nerr++; $display("FAIL conc_ch2_early: got done=%b run=%b want 0 1", done[2], running[2]); end
    nvec++; if (rd_count !== 30'd1) begin nerr++; $display("FAIL conc_ch2_cnt1: got %0d want 1", rd_count); end
    idle(1);
    nvec++; if (done[2] !== 1'b1 || running[2] !== 1'b0) begin nerr++; $display("FAIL conc_ch2_done: got done=%b run=%b want 1 0", done[2], running[2]); end
    cmd(2, 5, 0); cmd(3, 5, 0);
  endtask

  task automatic test_disable();
    rd_ch = 2'd0;
    cmd(0, 0, 100); cmd(0, 1, 0); cmd(0, 3, 0);
    idle(39); cmd(0, 2, 0);
    nvec++; if (rd_count !== 30'd60) begin nerr++; $display("FAIL dis_count: got %0d want 60", rd_count); end
    nvec++; if (running[0] !== 1'b0) begin nerr++; $display("FAIL dis_running: got %b want 0", running[0]); end
    idle(20);
    nvec++; if (rd_count !== 30'd60 || done[0] !== 1'b0) begin nerr++; $display("FAIL dis_hold: got cnt=%0d done=%b want 60 0", rd_count, done[0]); end
    cmd(0, 3, 0);
    idle(99);
    nvec++; if (done[0] !== 1'b0) begin nerr++; $display("FAIL reen_early: got %b want 0", done[0]); end
    idle(1);
    nvec++; if (done[0] !== 1'b1) begin nerr++; $display("FAIL reen_done: got %b want 1", done[0]); end
    cmd(0, 5, 0);
  endtask

  task automatic test_init_zero();
    cmd(1, 0, 0); cmd(1, 3, 0);
    nvec++; if (running[1] !== 1'b0 || done[1] !== 1'b0) begin nerr++; $display("FAIL init0_en: got run=%b done=%b want 0 0", running[1], done[1]); end
    idle(20);
    nvec++; if (running[1] !== 1'b0 || done[1] !== 1'b0) begin nerr++; $display("FAIL init0_later: got run=%b done=%b want 0 0", running[1], done[1]); end
  endtask

  task automatic test_restart();
    cmd(3, 0, 20); cmd(3, 1, 0); cmd(3, 4, 0);
    idle(10); cmd(3, 3, 0);
    idle(19);
    nvec++; if (done[3] !== 1'b0 || running[3] !== 1'b1) begin nerr++; $display("FAIL restart_early: got done=%b run=%b want 0 1", done[3], running[3]); end
    idle(1);
    nvec++; if (done[3] !== 1'b1 || running[3] !== 1'b0) begin nerr++; $display("FAIL restart_done: got done=%b run=%b want 1 0", done[3], running[3]); end
    cmd(3, 5, 0);
    idle(2);
  endtask

  task automatic test_irq_mask();
`ifdef TIMER_IRQ_MASK_EN
    cmd(0, 6, 2); cmd(0, 0, 5); cmd(1, 0, 10); cmd(0, 1, 0); cmd(1, 1, 0);
    cmd(0, 3, 0); cmd(1, 3, 0);
    idle(4);
    nvec++; if (done[0] !== 1'b1) begin nerr++; $display("FAIL mask_ch0_done: got %b want 1", done[0]); end
    idle(1);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL mask_irq_blocked: got %b want 0", irq); end
    idle(5);
    nvec++; if (done[1] !== 1'b1) begin nerr++; $display("FAIL mask_ch1_done: got %b want 1", done[1]); end
    idle(1);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL mask_irq_pass: got %b want 1", irq); end
    cmd(0, 6, 15);
`else
    cmd(0, 6, 0); cmd(0, 7, 0); cmd(0, 0, 5); cmd(0, 1, 0); cmd(0, 3, 0);
    idle(5);
    nvec++; if (done[0] !== 1'b1) begin nerr++; $display("FAIL nomask_done: got %b want 1", done[0]); end
    idle(1);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL nomask_irq: got %b want 1", irq); end
`endif
    cmd(0, 5, 0); cmd(1, 5, 0);
    idle(2);
  endtask

  task automatic test_async_reset();
    rd_ch = 2'd0;
    cmd(0, 0, 100); cmd(0, 1, 0); cmd(0, 3, 0);
    idle(29);
    #2 reset_n = 1'b0;
    #1;
    nvec++; if (running !== '0 || done !== '0 || missed !== '0) begin nerr++; $display("FAIL arst_flags: got run=%b done=%b miss=%b want 0", running, done, missed); end
    nvec++; if (irq !== 1'b0 || rd_count !== '0) begin nerr++; $display("FAIL arst_out: got irq=%b cnt=%0d want 0 0", irq, rd_count); end
    #4 reset_n = 1'b1;
    mdl_reset();
    @(posedge clk);
    #1;
    idle(150);
    nvec++; if (done !== '0 || running !== '0 || rd_count !== '0) begin nerr++; $display("FAIL arst_after: got done=%b run=%b cnt=%0d want 0", done, running, rd_count); end
  endtask

  task automatic test_random();
    int ch, op;
    longint data;
    logic [N_CH-1:0] er, ed, em;
    for (int i = 0; i < 2000; i++) begin
      rd_ch = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        ch = $urandom_range(0, 3);
        op = $urandom_range(0, 7);
        data = (op == 0) ? longint'($urandom_range(0, 30)) :
               (op == 1) ? longint'($urandom_range(0, 3)) : longint'($urandom_range(0, 15));
        cmd(ch, op, data);
      end else begin
        idle(1);
      end
      for (int c = 0; c < N_CH; c++) begin
        er[c] = m_run[c]; ed[c] = m_done[c]; em[c] = m_miss[c];
      end
      nvec++; if (running !== er) begin nerr++; $display("FAIL rnd_running @%0d: got %b want %b", cyc, running, er); end
      nvec++; if (done !== ed) begin nerr++; $display("FAIL rnd_done @%0d: got %b want %b", cyc, done, ed); end
      nvec++; if (missed !== em) begin nerr++; $display("FAIL rnd_missed @%0d: got %b want %b", cyc, missed, em); end
      nvec++; if (irq !== m_irq) begin nerr++; $display("FAIL rnd_irq @%0d: got %b want %b", cyc, irq, m_irq); end
      nvec++; if (longint'(rd_count) != m_count(int'(rd_ch))) begin nerr++; $display("FAIL rnd_count ch%0d @%0d: got %0d want %0d", rd_ch, cyc, rd_count, m_count(int'(rd_ch))); end
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
`ifdef TIMER_IRQ_MASK_EN
    cmd(0, 6, 15);
`endif
    test_oneshot();
    test_periodic();
    test_concurrent();
    test_disable();
    test_init_zero();
    test_restart();
    test_irq_mask();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
